dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Dual-issue in-order dispatch scheduler between the decode/rename pipeline register and the four
//  reservation stations (ALU, SFU, BRU, AGU). Tracks free entries per station with credit counters,
//  grants dispatch of the two decoded instructions in program order and stalls the decode/rename
//  register when a pair cannot fully dispatch. Clears credit state to empty stations on branch recovery.
// PARAMETERS
//  ALU_DEPTH  16  ALU reservation station entries
//  SFU_DEPTH  8   SFU reservation station entries
//  BRU_DEPTH  8   BRU reservation station entries
//  AGU_DEPTH  8   AGU reservation station entries
//  CNT_W      5   credit counter width; every *_DEPTH <= 2^CNT_W-1
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  recover    in   1        mispredict flush; stations squash all entries this cycle
//  valid_1    in   1        slot-1 (older) instruction present
//  rs_num_1   in   2        slot-1 target station: 0 ALU, 1 SFU, 2 BRU, 3 AGU
//  valid_2    in   1        slot-2 (younger) instruction present
//  rs_num_2   in   2        slot-2 target station, same encoding
//  issue_alu  in   1        ALU station issued one entry (frees one slot); likewise:
//  issue_sfu  in   1        SFU entry freed
//  issue_bru  in   1        BRU entry freed
//  issue_agu  in   1        AGU entry freed
//  disp_1     out  1        write slot-1 into station rs_num_1 this cycle
//  disp_2     out  1        write slot-2 into station rs_num_2 this cycle
//  stall      out  1        hold decode/rename register (its en = ~stall)
//  free_cnt   out  4*CNT_W  credits {AGU,BRU,SFU,ALU}, registered
//  err_ovf    out  1        sticky: free received while station already empty
// BEHAVIOUR
//  Reset: credits = *_DEPTH, state = BOTH, err_ovf = 0; disp_1/disp_2/stall = 0 while valid_* = 0.
//  Grants combinational from registered credits c[] and state; free credit from issue_* is
//   usable only next cycle (no same-cycle bypass).
//  State BOTH (pair pending):
//   g1 = valid_1 & c[rs_num_1] >= 1.
//   g2 = g1 & valid_2 & c[rs_num_2] >= 1 + (rs_num_2 == rs_num_1).
//   disp_1 = g1, disp_2 = g2; slot 2 never dispatches before slot 1.
//   stall = (valid_1 & ~g1) | (valid_2 & ~g2).
//   g1 & valid_2 & ~g2 -> SECOND; otherwise stay BOTH.
//   valid_1 = 0 with valid_2 = 1 is illegal; treat slot 2 as invalid (no grant, no stall from it).
//  State SECOND (slot 1 already dispatched, register held):
//   disp_1 = 0.
//   disp_2 = g2s = valid_2 & c[rs_num_2] >= 1.
//   stall = ~g2s.
//   g2s -> BOTH.
//  Credit update per station k: c_next = c - d_k + f_k; d_k in 0..2 = dispatches to k; f_k = issue_k.
//   Dispatch and free same cycle both apply.
//   Free with c == DEPTH and d_k == 0: counter holds at DEPTH and err_ovf sets on the next edge.
//  recover (highest priority, overrides state): disp_1 = disp_2 = 0, stall = 0.
//   Next edge: state = BOTH, all credits = DEPTH, issue_* ignored that cycle; err_ovf unchanged.
//  reset mid-operation: immediate return to reset values regardless of state.
//  Latency: dispatch decision same cycle as valid; credit effect visible one cycle later.
// TESTING
//  1 Reset -> free_cnt = {8,8,8,16}, stall = 0, disp_* = 0, err_ovf = 0.
//  2 valid_1 = valid_2 = 1, both ALU, no issue, 8 cycles -> disp both each cycle, ALU credit 0;
//    cycle 9 -> disp_1 = 0, stall = 1.
//  3 ALU credit 1, both ALU -> disp_1 = 1, disp_2 = 0, stall = 1, state SECOND;
//    issue_alu pulse -> next cycle disp_2 = 1, stall = 0.
//  4 recover while in SECOND -> disp_* = 0, stall = 0; next cycle free_cnt = {8,8,8,16}, state BOTH.
//  5 BRU credit 3, pair to BRU + issue_bru same cycle -> BRU credit 2 next cycle.
//  6 SFU credit 8, issue_sfu = 1, no dispatch -> SFU stays 8, err_ovf = 1 until reset.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
// Decode/rename-to-dispatch handshake bundle: the two decoded slots going in,
// the per-slot dispatch grants and the decode-register stall coming back.
interface dispatch_ctrl_if;
  logic       valid_1;
  logic [1:0] rs_num_1;
  logic       valid_2;
  logic [1:0] rs_num_2;
  logic       disp_1;
  logic       disp_2;
  logic       stall;

  // Decode/rename side drives the instruction pair
  modport master (
    output valid_1, rs_num_1, valid_2, rs_num_2,
    input  disp_1, disp_2, stall
  );

  // Dispatch scheduler side returns grants and stall
  modport slave (
    input  valid_1, rs_num_1, valid_2, rs_num_2,
    output disp_1, disp_2, stall
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dual-issue in-order dispatch scheduler. Keeps one credit counter per
// reservation station (ALU, SFU, BRU, AGU), grants the decoded pair in program
// order from registered credits, and remembers when only the older slot went
// out so the held pair re-offers just the younger slot next cycle.
module dispatch_ctrl #(
  parameter int ALU_DEPTH = 16,
  parameter int SFU_DEPTH = 8,
  parameter int BRU_DEPTH = 8,
  parameter int AGU_DEPTH = 8,
  parameter int CNT_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recover,
  input  logic               issue_alu,
  input  logic               issue_sfu,
  input  logic               issue_bru,
  input  logic               issue_agu,
  output logic [4*CNT_W-1:0] free_cnt,
  output logic               err_ovf,
  dispatch_ctrl_if.slave     dif
);

  typedef enum logic {
    ST_BOTH   = 1'b0,  // full pair still pending
    ST_SECOND = 1'b1   // older slot dispatched, younger slot waiting
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cred [4];
  logic [3:0]       issue_vec;
  logic [3:0]       ovf_vec;
  logic [CNT_W-1:0] cred_1;
  logic [CNT_W-1:0] cred_2;
  logic [CNT_W-1:0] need_2;
  logic             g1;
  logic             g2;
  logic             stall_c;

  assign issue_vec = {issue_agu, issue_bru, issue_sfu, issue_alu};
  assign cred_1    = cred[dif.rs_num_1];
  assign cred_2    = cred[dif.rs_num_2];
  // Two instructions to the same station need two credits in the same cycle.
  assign need_2    = (dif.rs_num_1 == dif.rs_num_2) ? CNT_W'(2) : CNT_W'(1);

  // Grant and stall decisions from registered credits; recover masks everything.
  always_comb begin
    g1      = 1'b0;
    g2      = 1'b0;
    stall_c = 1'b0;
    if (!recover) begin
      if (state == ST_BOTH) begin
        g1      = dif.valid_1 && (cred_1 != '0);
        // A lone younger slot is not a legal pair, so it never grants or stalls.
        g2      = g1 && dif.valid_2 && (cred_2 >= need_2);
        stall_c = (dif.valid_1 && !g1) || (dif.valid_1 && dif.valid_2 && !g2);
      end else begin
        g2      = dif.valid_2 && (cred_2 != '0);
        stall_c = !g2;
      end
    end
  end

  assign dif.disp_1 = g1;
  assign dif.disp_2 = g2;
  assign dif.stall  = stall_c;

  // Pair-progress FSM: park in SECOND when only the older slot got out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOTH;
    end else if (recover) begin
      state <= ST_BOTH;
    end else begin
      case (state)
        ST_BOTH:   if (g1 && dif.valid_2 && !g2) state <= ST_SECOND;
        ST_SECOND: if (g2) state <= ST_BOTH;
        default:   state <= ST_BOTH;
      endcase
    end
  end

  // One credit counter per station; index 0..3 = ALU, SFU, BRU, AGU.
  for (genvar gi = 0; gi < 4; gi++) begin : g_station
    localparam int DEP = (gi == 0) ? ALU_DEPTH :
                         (gi == 1) ? SFU_DEPTH :
                         (gi == 2) ? BRU_DEPTH : AGU_DEPTH;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       used;
    logic             hit_1;
    logic             hit_2;

    assign hit_1 = g1 && (dif.rs_num_1 == 2'(gi));
    assign hit_2 = g2 && (dif.rs_num_2 == 2'(gi));
    assign used  = {1'b0, hit_1} + {1'b0, hit_2};
    // A free arriving while the station is already empty has nothing to return.
    assign ovf_vec[gi] = issue_vec[gi] && (used == 2'd0) && (cnt == CNT_W'(DEP));

    // Credits drop by dispatches and rise by issued entries; recover refills.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= CNT_W'(DEP);
      end else if (recover) begin
        cnt <= CNT_W'(DEP);
      end else if (!ovf_vec[gi]) begin
        cnt <= cnt - CNT_W'(used) + CNT_W'(issue_vec[gi]);
      end
    end

    assign cred[gi] = cnt;
    assign free_cnt[gi*CNT_W +: CNT_W] = cnt;
  end

  // Sticky overflow flag; frees are ignored during recover so it cannot set then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
    end else if (!recover && (ovf_vec != 4'b0000)) begin
      err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: a directed vector table with hand-derived
// expectations, a few hand sequences (async reset mid-pair), then random
// traffic compared against a credit/queue-level reference model.
module tb_dispatch_ctrl;
  localparam int CNT_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        recover;
  logic        issue_alu, issue_sfu, issue_bru, issue_agu;
  logic [19:0] free_cnt;
  logic        err_ovf;

  dispatch_ctrl_if dif ();

  dispatch_ctrl #(
    .ALU_DEPTH(16), .SFU_DEPTH(8), .BRU_DEPTH(8), .AGU_DEPTH(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .recover(recover),
    .issue_alu(issue_alu), .issue_sfu(issue_sfu),
    .issue_bru(issue_bru), .issue_agu(issue_agu),
    .free_cnt(free_cnt), .err_ovf(err_ovf), .dif(dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rec;
    bit       v1;
    bit [1:0] r1;
    bit       v2;
    bit [1:0] r2;
    bit [3:0] iss;
    bit       d1;
    bit       d2;
    bit       st;
    int       ea, es, eb, eg;
    bit       err;
  } vec_t;

  vec_t tab[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: free entries per station and whether the pair is half done.
  int cm[4];
  bit sec_m;
  bit err_m;

  function automatic int depth(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic int pack_cnt(input int a, input int s, input int b, input int g);
    return a | (s << 5) | (b << 10) | (g << 15);
  endfunction

  function automatic vec_t mk(input bit rec, input bit v1, input bit [1:0] r1,
                              input bit v2, input bit [1:0] r2, input bit [3:0] iss,
                              input bit d1, input bit d2, input bit st,
                              input int ea, input int es, input int eb, input int eg,
                              input bit err);
    vec_t v;
    v.rec = rec; v.v1 = v1; v.r1 = r1; v.v2 = v2; v.r2 = r2; v.iss = iss;
    v.d1 = d1; v.d2 = d2; v.st = st;
    v.ea = ea; v.es = es; v.eb = eb; v.eg = eg; v.err = err;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) cm[k] = depth(k);
    sec_m = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive after the edge, compare at the falling edge,
  // advance the model after the next rising edge.
  task automatic apply(input string tag, input bit rec, input bit v1, input bit [1:0] r1,
                       input bit v2, input bit [1:0] r2, input bit [3:0] iss,
                       input bit has_tab, input vec_t e);
    bit p_d1, p_d2, p_st;
    int need, used;
    recover = rec; dif.valid_1 = v1; dif.rs_num_1 = r1; dif.valid_2 = v2; dif.rs_num_2 = r2;
    {issue_agu, issue_bru, issue_sfu, issue_alu} = iss;
    @(negedge clk);
    p_d1 = 1'b0; p_d2 = 1'b0; p_st = 1'b0;
    if (!rec) begin
      if (!sec_m) begin
        need = (r1 == r2) ? 2 : 1;
        p_d1 = v1 && (cm[r1] >= 1);
        p_d2 = p_d1 && v2 && (cm[r2] >= need);
        p_st = (v1 && !p_d1) || (v1 && v2 && !p_d2);
      end else begin
        p_d2 = v2 && (cm[r2] >= 1);
        p_st = !p_d2;
      end
    end
    chk({tag, " disp_1"}, int'(dif.disp_1), int'(p_d1));
    chk({tag, " disp_2"}, int'(dif.disp_2), int'(p_d2));
    chk({tag, " stall"},  int'(dif.stall),  int'(p_st));
    chk({tag, " free_cnt"}, int'(free_cnt), pack_cnt(cm[0], cm[1], cm[2], cm[3]));
    chk({tag, " err_ovf"}, int'(err_ovf), int'(err_m));
    $display("%s rec=%0b v1=%0b r1=%0d v2=%0b r2=%0d iss=%b -> d1=%0b d2=%0b st=%0b free=%h err=%0b",
             tag, rec, v1, r1, v2, r2, iss, dif.disp_1, dif.disp_2, dif.stall, free_cnt, err_ovf);
    if (has_tab) begin
      chk({tag, " tab disp_1"}, int'(dif.disp_1), int'(e.d1));
      chk({tag, " tab disp_2"}, int'(dif.disp_2), int'(e.d2));
      chk({tag, " tab stall"},  int'(dif.stall),  int'(e.st));
      chk({tag, " tab free_cnt"}, int'(free_cnt), pack_cnt(e.ea, e.es, e.eb, e.eg));
      chk({tag, " tab err_ovf"}, int'(err_ovf), int'(e.err));
    end
    @(posedge clk);
    #1;
    if (rec) begin
      for (int k = 0; k < 4; k++) cm[k] = depth(k);
      sec_m = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        used = ((p_d1 && r1 == 2'(k)) ? 1 : 0) + ((p_d2 && r2 == 2'(k)) ? 1 : 0);
        if (iss[k] && used == 0 && cm[k] == depth(k)) err_m = 1'b1;
        else cm[k] = cm[k] - used + (iss[k] ? 1 : 0);
      end
      sec_m = sec_m ? !p_d2 : (p_d1 && v2 && !p_d2);
    end
  endtask

  task automatic idle_inputs();
    recover = 1'b0; dif.valid_1 = 1'b0; dif.rs_num_1 = 2'd0; dif.valid_2 = 1'b0; dif.rs_num_2 = 2'd0;
    {issue_agu, issue_bru, issue_sfu, issue_alu} = 4'b0000;
  endtask

  initial begin
    vec_t none;
    int   p;
    none = mk(0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    reset = 1'b1;

    // Directed table: {inputs, expected outputs seen during that cycle}.
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 16, 8, 8, 8, 0));  // reset state
    tab.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 16, 8, 8, 8, 0));  // lone slot 2 ignored
    for (int i = 0; i < 8; i++)
      tab.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 1, 1, 0, 16 - 2 * i, 8, 8, 8, 0));
    tab.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 0, 0, 1, 0, 8, 8, 8, 0));   // ALU exhausted
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 8, 8, 8, 0));   // free one ALU
    tab.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 1, 0, 1, 1, 8, 8, 8, 0));   // split -> SECOND
    tab.push_back(mk(0, 1, 0, 1, 0, 4'b0001, 0, 0, 1, 0, 8, 8, 8, 0));   // issue not bypassed
    tab.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 0, 1, 0, 1, 8, 8, 8, 0));   // slot 2 goes
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 8, 8, 8, 0));
    tab.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 1, 0, 1, 1, 8, 8, 8, 0));   // SECOND again
    tab.push_back(mk(1, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 8, 8, 8, 0));   // recover
    tab.push_back(mk(0, 1, 0, 1, 1, 4'b0000, 1, 1, 0, 16, 8, 8, 8, 0));  // refilled, BOTH
    tab.push_back(mk(0, 1, 2, 1, 2, 4'b0000, 1, 1, 0, 15, 7, 8, 8, 0));
    tab.push_back(mk(0, 1, 2, 1, 2, 4'b0000, 1, 1, 0, 15, 7, 6, 8, 0));
    tab.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 1, 0, 0, 15, 7, 4, 8, 0));
    tab.push_back(mk(0, 1, 2, 1, 2, 4'b0100, 1, 1, 0, 15, 7, 3, 8, 0));  // BRU 3 -2 +1
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 15, 7, 2, 8, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 15, 8, 2, 8, 0));  // free into full SFU
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 15, 8, 2, 8, 1));  // sticky error
    tab.push_back(mk(0, 1, 3, 1, 3, 4'b0000, 1, 1, 0, 15, 8, 2, 8, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 15, 8, 2, 6, 1));

    // Reset values checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset free_cnt", int'(free_cnt), pack_cnt(16, 8, 8, 8));
    chk("reset err_ovf", int'(err_ovf), 0);
    chk("reset stall", int'(dif.stall), 0);
    reset = 1'b0;

    for (int i = 0; i < tab.size(); i++)
      apply($sformatf("tab%0d", i), tab[i].rec, tab[i].v1, tab[i].r1, tab[i].v2, tab[i].r2,
            tab[i].iss, 1'b1, tab[i]);

    // Drive SFU down to one credit and split a pair so the FSM sits in SECOND.
    for (int i = 0; i < 3; i++) apply("seq_sfu", 0, 1, 1, 1, 1, 4'b0000, 1'b0, none);
    apply("seq_sfu", 0, 1, 1, 0, 0, 4'b0000, 1'b0, none);
    apply("seq_split", 0, 1, 1, 1, 1, 4'b0000, 1'b0, none);
    // Asynchronous reset mid-cycle: values return before any clock edge.
    reset = 1'b1;
    #2;
    chk("async free_cnt", int'(free_cnt), pack_cnt(16, 8, 8, 8));
    chk("async err_ovf", int'(err_ovf), 0);
    chk("async disp_1", int'(dif.disp_1), 1);
    chk("async disp_2", int'(dif.disp_2), 1);
    chk("async stall", int'(dif.stall), 0);
    $display("async_reset free=%h err=%0b d1=%0b d2=%0b st=%0b",
             free_cnt, err_ovf, dif.disp_1, dif.disp_2, dif.stall);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Random traffic in alternating drain/refill phases.
    for (int i = 0; i < 600; i++) begin
      p = ((i / 50) % 2 == 0) ? 12 : 55;
      apply($sformatf("rnd%0d", i),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            {($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p),
             ($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p)},
            1'b0, none);
      if (i == 300) begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
